// File: rtl/inverse_clarke_seq_if.sv
// inverse_clarke_seq_if: valid/ready input pair and phase-output bundle for inverse_clarke_seq.
interface inverse_clarke_seq_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] v_alpha;
    logic signed [15:0] v_beta;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] v_a;
    logic signed [15:0] v_b;
    logic signed [15:0] v_c;
    logic               sat;
    modport master (
        output in_valid, v_alpha, v_beta, out_ready,
        input  in_ready, out_valid, v_a, v_b, v_c, sat
    );
    modport slave (
        input  in_valid, v_alpha, v_beta, out_ready,
        output in_ready, out_valid, v_a, v_b, v_c, sat
    );
endinterface

// File: rtl/inverse_clarke_seq.sv
// inverse_clarke_seq: power-invariant inverse Clarke (alpha,beta -> a,b,c) on one shared 16x16 multiplier.
// Define INV_CLARKE_SAT_EN to clamp results and report sat; otherwise results wrap to 16 bits.
module inverse_clarke_seq #(
    parameter int IN_HALF_SCALE = 1
) (
    input logic clk,
    input logic rst,
    inverse_clarke_seq_if.slave io
);
    localparam int S = (IN_HALF_SCALE != 0) ? 14 : 15;
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL1 = 3'd1;
    localparam logic [2:0] MUL2 = 3'd2;
    localparam logic [2:0] MUL3 = 3'd3;
    localparam logic [2:0] SUM  = 3'd4;
    localparam logic [2:0] HOLD = 3'd5;
    localparam logic signed [15:0] K1 = 16'sh6882;
    localparam logic signed [15:0] K2 = 16'sh3441;
    localparam logic signed [15:0] K3 = 16'sh5A82;

    logic [2:0]         state_q, state_d;
    logic signed [15:0] alpha_q, alpha_d, beta_q, beta_d;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic signed [31:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic signed [33:0] sa, sb, sc;
    logic [16:0]        ra, rb, rc;
    logic [15:0]        va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    logic               sat_q, sat_d, out_valid_q, out_valid_d;

    // Result in low 16 bits, clip flag in bit 16.
`ifdef INV_CLARKE_SAT_EN
    function automatic logic [16:0] reduce(input logic signed [33:0] x);
        return (x > 34'sd32767) ? {1'b1, 16'h7FFF} :
               (x < -34'sd32768) ? {1'b1, 16'h8000} : {1'b0, x[15:0]};
    endfunction
`else
    function automatic logic [16:0] reduce(input logic signed [33:0] x);
        return {1'b0, 16'(x)};
    endfunction
`endif

    always_comb begin
        mul_a = (state_q == MUL1) ? K1 : (state_q == MUL2) ? K2 : K3;
        mul_b = (state_q == MUL3) ? beta_q : alpha_q;
        prod  = 32'(mul_a) * 32'(mul_b);
        sa    = 34'(p1_q);
        sb    = 34'(p3_q) - 34'(p2_q);
        sc    = -34'(p2_q) - 34'(p3_q);
        ra    = reduce(sa >>> S);
        rb    = reduce(sb >>> S);
        rc    = reduce(sc >>> S);
    end

    always_comb begin
        state_d     = state_q;
        alpha_d     = alpha_q;
        beta_d      = beta_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        va_d        = va_q;
        vb_d        = vb_q;
        vc_d        = vc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                alpha_d = io.v_alpha;
                beta_d  = io.v_beta;
                state_d = MUL1;
            end
            MUL1: begin
                p1_d    = prod;
                state_d = MUL2;
            end
            MUL2: begin
                p2_d    = prod;
                state_d = MUL3;
            end
            MUL3: begin
                p3_d    = prod;
                state_d = SUM;
            end
            SUM: begin
                va_d        = ra[15:0];
                vb_d        = rb[15:0];
                vc_d        = rc[15:0];
                sat_d       = ra[16] | rb[16] | rc[16];
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: if (io.out_ready) begin
                out_valid_d = 1'b0;
                sat_d       = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alpha_q     <= '0;
            beta_q      <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
            va_q        <= '0;
            vb_q        <= '0;
            vc_q        <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
            va_q        <= va_d;
            vb_q        <= vb_d;
            vc_q        <= vc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.v_a       = va_q;
    assign io.v_b       = vb_q;
    assign io.v_c       = vc_q;
    assign io.sat       = sat_q;
endmodule

// File: tb/tb_inverse_clarke_seq.sv
// tb_inverse_clarke_seq: randomized and directed checks of inverse_clarke_seq against an arithmetic model.
// Honours INV_CLARKE_SAT_EN the same way as the design.
module tb_inverse_clarke_seq;
    localparam int S = 14;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    inverse_clarke_seq_if io();

    inverse_clarke_seq #(.IN_HALF_SCALE(1)) dut (
        .clk(clk),
        .rst(rst),
        .io(io.slave)
    );

    always #5 clk = ~clk;

    // Real transform with floor(x / 2^S), then clamp or wrap to 16 bits.
    function automatic void model(input logic signed [15:0] al, input logic signed [15:0] be,
                                  output logic [15:0] ea, output logic [15:0] eb,
                                  output logic [15:0] ec, output logic es);
        longint x[3];
        logic [15:0] y[3];
        x[0] = (26754 * longint'(al)) >>> S;
        x[1] = (-13377 * longint'(al) + 23170 * longint'(be)) >>> S;
        x[2] = (-13377 * longint'(al) - 23170 * longint'(be)) >>> S;
        es = 1'b0;
        for (int i = 0; i < 3; i++) begin
`ifdef INV_CLARKE_SAT_EN
            if (x[i] > 32767) begin x[i] = 32767; es = 1'b1; end
            else if (x[i] < -32768) begin x[i] = -32768; es = 1'b1; end
`endif
            y[i] = 16'(x[i]);
        end
        ea = y[0];
        eb = y[1];
        ec = y[2];
    endfunction

    task automatic do_txn(input logic [15:0] al, input logic [15:0] be, input int dly,
                          output logic [15:0] ga, output logic [15:0] gb,
                          output logic [15:0] gc, output logic gs, output int lat);
        int w = 0;
        while (!io.in_ready && w < 20) begin @(posedge clk); #1; w++; end
        io.in_valid = 1'b1;
        io.v_alpha  = al;
        io.v_beta   = be;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        lat = 0;
        while (!io.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!io.out_valid) begin
            errors++;
            $display("FAIL txn_timeout out_valid=%b required 1", io.out_valid);
        end
        ga = io.v_a;
        gb = io.v_b;
        gc = io.v_c;
        gs = io.sat;
        repeat (dly) begin @(posedge clk); #1; end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({io.in_ready, io.out_valid, io.sat} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags in_ready/out_valid/sat=%b required 100", {io.in_ready, io.out_valid, io.sat});
        end
        checks++;
        if ({io.v_a, io.v_b, io.v_c} !== 48'd0) begin
            errors++;
            $display("FAIL reset_outputs abc=%h required 0", {io.v_a, io.v_b, io.v_c});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic [15:0] ga, gb, gc;
        logic gs;
        int lat;
        do_txn(16'h0000, 16'h0000, 0, ga, gb, gc, gs, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL zero_latency got %0d required 4", lat);
        end
        checks++;
        if ({ga, gb, gc, gs} !== 49'd0) begin
            errors++;
            $display("FAIL zero_result abc=%h sat=%b required 0", {ga, gb, gc}, gs);
        end
        checks++;
        if ({io.out_valid, io.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_return out_valid/in_ready=%b required 01", {io.out_valid, io.in_ready});
        end
    endtask

    task automatic test_directed();
        logic [15:0] ga, gb, gc;
        logic gs;
        int lat;
        logic [15:0] xa, xb, xc;
        logic xs;
        do_txn(16'h2000, 16'h0000, 1, ga, gb, gc, gs, lat);
        checks++;
        if ({ga, gb, gc, gs} !== {16'd13377, -16'sd6689, -16'sd6689, 1'b0}) begin
            errors++;
            $display("FAIL alpha_only got %0d %0d %0d sat=%b required 13377 -6689 -6689 0",
                     $signed(ga), $signed(gb), $signed(gc), gs);
        end
        do_txn(16'h0000, 16'h2000, 0, ga, gb, gc, gs, lat);
        checks++;
        if ({ga, gb, gc, gs} !== {16'd0, 16'd11585, -16'sd11585, 1'b0}) begin
            errors++;
            $display("FAIL beta_only got %0d %0d %0d sat=%b required 0 11585 -11585 0",
                     $signed(ga), $signed(gb), $signed(gc), gs);
        end
        do_txn(16'h7FFF, 16'h7FFF, 2, ga, gb, gc, gs, lat);
`ifdef INV_CLARKE_SAT_EN
        {xa, xb, xc, xs} = {16'd32767, 16'd19585, 16'h8000, 1'b1};
`else
        {xa, xb, xc, xs} = {16'hD102, 16'd19585, 16'hE27C, 1'b0};
`endif
        checks++;
        if ({ga, gb, gc, gs} !== {xa, xb, xc, xs}) begin
            errors++;
            $display("FAIL full_scale got %h %h %h sat=%b required %h %h %h %b", ga, gb, gc, gs, xa, xb, xc, xs);
        end
    endtask

    task automatic test_random();
        logic [15:0] al, be, ga, gb, gc, ea, eb, ec;
        logic gs, es;
        int lat;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: al = 16'h7FFF;
                1: al = 16'h8000;
                default: al = 16'($urandom);
            endcase
            be = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            model(al, be, ea, eb, ec, es);
            do_txn(al, be, $urandom_range(0, 3), ga, gb, gc, gs, lat);
            checks++;
            if ({ga, gb, gc, gs} !== {ea, eb, ec, es} || lat !== 4) begin
                errors++;
                $display("FAIL random a=%h b=%h got %h %h %h sat=%b lat=%0d required %h %h %h %b lat=4",
                         al, be, ga, gb, gc, gs, lat, ea, eb, ec, es);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ea, eb, ec, ga, gb, gc;
        logic es, gs;
        int w = 0;
        int lat;
        model(16'h1234, 16'hE001, ea, eb, ec, es);
        io.in_valid = 1'b1;
        io.v_alpha  = 16'h1234;
        io.v_beta   = 16'hE001;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        while (!io.out_valid && w < 20) begin @(posedge clk); #1; w++; end
        for (int i = 0; i < 10; i++) begin
            io.in_valid = i[0];
            io.v_alpha  = 16'($urandom);
            io.v_beta   = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({io.out_valid, io.in_ready, io.v_a, io.v_b, io.v_c, io.sat} !== {2'b10, ea, eb, ec, es}) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d vld/rdy=%b%b abc=%h %h %h sat=%b required 10 %h %h %h %b",
                         i, io.out_valid, io.in_ready, io.v_a, io.v_b, io.v_c, io.sat, ea, eb, ec, es);
            end
        end
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        checks++;
        if ({io.out_valid, io.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release out_valid/in_ready=%b required 01", {io.out_valid, io.in_ready});
        end
        model(16'hC000, 16'h3000, ea, eb, ec, es);
        do_txn(16'hC000, 16'h3000, 0, ga, gb, gc, gs, lat);
        checks++;
        if ({ga, gb, gc, gs} !== {ea, eb, ec, es} || lat !== 4) begin
            errors++;
            $display("FAIL backpressure_next got %h %h %h sat=%b lat=%0d required %h %h %h %b lat=4",
                     ga, gb, gc, gs, lat, ea, eb, ec, es);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] ea, eb, ec, ga, gb, gc;
        logic es, gs;
        int lat;
        io.in_valid = 1'b1;
        io.v_alpha  = 16'h4000;
        io.v_beta   = 16'h2000;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({io.out_valid, io.in_ready, io.sat, io.v_a, io.v_b, io.v_c} !== {3'b010, 48'd0}) begin
            errors++;
            $display("FAIL midop_reset vld/rdy/sat=%b%b%b abc=%h %h %h required 010 0 0 0",
                     io.out_valid, io.in_ready, io.sat, io.v_a, io.v_b, io.v_c);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (io.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_no_output cyc=%0d out_valid=%b required 0", i, io.out_valid);
            end
        end
        model(16'h0F00, 16'hF100, ea, eb, ec, es);
        do_txn(16'h0F00, 16'hF100, 1, ga, gb, gc, gs, lat);
        checks++;
        if ({ga, gb, gc, gs} !== {ea, eb, ec, es}) begin
            errors++;
            $display("FAIL midop_fresh got %h %h %h sat=%b required %h %h %h %b", ga, gb, gc, gs, ea, eb, ec, es);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.v_alpha   = '0;
        io.v_beta    = '0;
        test_reset();
        test_zero();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inverse_clarke_seq.md
Name: inverse_clarke_seq

Overview:
- Inverse Clarke transform: converts the stationary-frame pair (v_alpha, v_beta) back to three phase quantities (a, b, c).
- Sits on the FOC output path, after the inverse Park stage and before SVPWM/PWM duty generation. It mirrors the forward Clarke stage on the current-sense side.
- One shared signed 16x16 multiplier is time-multiplexed by a small FSM. Input and output use valid/ready handshakes.
- Power-invariant form: a = sqrt(2/3)·α; b = −sqrt(1/6)·α + sqrt(1/2)·β; c = −sqrt(1/6)·α − sqrt(1/2)·β.

Parameters:
- IN_HALF_SCALE, default 1. When 1, inputs are half-scale (same convention as the forward Clarke outputs), so the final shift is 14. When 0, inputs are full-scale and the shift is 15.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pair is valid.
- in_ready  out  1  block can accept an input pair.
- v_alpha  in  16  signed alpha component.
- v_beta  in  16  signed beta component.
- out_valid  out  1  phase outputs are valid.
- out_ready  in  1  downstream accepts the outputs.
- v_a, v_b, v_c  out  16 each  signed phase outputs.
- sat  out  1  set if any phase of the current result was clipped (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, v_a=v_b=v_c=0, sat=0. All product and accumulator registers are cleared.
- Constants (Q15 signed):
  - K1 = 16'sh6882, sqrt(2/3)
  - K2 = 16'sh3441, sqrt(1/6)
  - K3 = 16'sh5A82, sqrt(1/2)
- S = 14 if IN_HALF_SCALE else 15.
- FSM states: IDLE → MUL1 → MUL2 → MUL3 → SUM → HOLD → IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch v_alpha/v_beta into alpha_r/beta_r and go to MUL1. in_ready is combinational from state (high only in IDLE).
  - MUL1: p1 <= K1*alpha_r (32-bit signed).
  - MUL2: p2 <= K2*alpha_r.
  - MUL3: p3 <= K3*beta_r.
  - SUM: form 34-bit sums, then arithmetic-shift right by S (floor toward −inf):
    - sa = p1
    - sb = −p2 + p3
    - sc = −p2 − p3
    - Reduce each to 16 bits per the Optional Feature, register onto v_a/v_b/v_c, set out_valid=1, go to HOLD.
  - HOLD: outputs and out_valid are held stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE in the same edge.
- Latency: input accept edge at cycle 0 → out_valid high after the cycle-4 edge. Minimum initiation interval is 6 cycles (accept, 3× MUL, SUM, HOLD with out_ready=1).
- in_valid is ignored whenever state≠IDLE; no input is queued.
- v_a/v_b/v_c change only on the SUM edge or on reset.
- rst asserted mid-operation (any state) aborts the computation on that edge:
  - all reset values apply; the in-flight sample is dropped.
  - no out_valid pulse follows the reset.
- Exactly one multiplier instance is used; the products are not computed in parallel.

Optional Feature:
- Macro INV_CLARKE_SAT_EN.
- Defined: each shifted sum is clamped to [−32768, 32767]. sat=1 on the SUM edge if any phase clamped, held with the outputs, and cleared when out_valid clears.
- Undefined: each shifted sum is truncated to its low 16 bits (two's-complement wrap). sat is tied to 0.

Test Plan:
- Reset, then α=0, β=0 with in_valid=1, out_ready=1 → a=b=c=0; out_valid rises 4 cycles after accept; in_ready returns high 1 cycle after out_valid.
- IN_HALF_SCALE=1, α=16'sh2000, β=0 → a=13377, b=−6689, c=−6689, sat=0.
- IN_HALF_SCALE=1, α=0, β=16'sh2000 → a=0, b=11585, c=−11585.
- INV_CLARKE_SAT_EN defined, α=β=16'sh7FFF:
  - expected: a=32767, b=19585, c=−32768, sat=1.
  - without the macro: a and c are the wrapped low 16 bits, sat=0.
- Backpressure:
  - hold out_ready=0 for 10 cycles after out_valid rises; toggle in_valid with new data throughout.
  - expected: outputs and out_valid stable, in_ready=0, new data not taken.
  - release out_ready → one handshake completes, then the next sample is accepted from IDLE.
- Assert rst for 1 cycle during MUL2 → next cycle all outputs 0, out_valid=0, in_ready=1; a fresh sample afterwards computes correctly.
